mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous memory.
// Handles registered grants, bounded hold with lock override, and read-data tagging.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_HOLD   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  r0_req,
    input  logic                  r1_req,
    input  logic                  r0_lock,
    input  logic                  r1_lock,
    input  logic                  r0_we,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r0_data,
    input  logic [DATA_WIDTH-1:0] r1_data,
    output logic                  r0_gnt,
    output logic                  r1_gnt,
    output logic                  r0_rvalid,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic [DATA_WIDTH-1:0] mem_in,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data
);

    // Handshake: a requester holds rx_req high; every cycle in which rx_gnt and
    // rx_req are both high is one memory access using that cycle's we/addr/data.
    // Reads return on rdata one cycle later, qualified by rx_rvalid.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic [3:0]            hold_q, hold_d, hold_inc;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_tag_q, rd_tag_d;

    logic                  cur;
    logic                  granted;
    logic                  cur_req, cur_lock, cur_we, other_req;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  access;
    logic                  winner;

    always_comb begin
        cur       = (state_q == GRANT1);
        granted   = (state_q == GRANT0) || (state_q == GRANT1);
        cur_req   = cur ? r1_req  : r0_req;
        cur_lock  = cur ? r1_lock : r0_lock;
        cur_we    = cur ? r1_we   : r0_we;
        cur_addr  = cur ? r1_addr : r0_addr;
        cur_data  = cur ? r1_data : r0_data;
        other_req = cur ? r0_req  : r1_req;
        access    = granted && cur_req;

        // Memory controls are forced to zero whenever no access is issued.
        mem_we   = access ? cur_we   : 1'b0;
        mem_addr = access ? cur_addr : '0;
        mem_data = access ? cur_data : '0;

        hold_inc = (access && (hold_q != HOLD_MAX)) ? hold_q + 4'd1 : hold_q;
        winner   = (r0_req && r1_req) ? ~last_q : r1_req;

        state_d   = state_q;
        last_d    = last_q;
        hold_d    = hold_inc;
        rd_pend_d = access && !cur_we;
        rd_tag_d  = cur;

        case (state_q)
            IDLE: begin
                hold_d = 4'd0;
                if (r0_req || r1_req) begin
                    last_d  = winner;
                    state_d = winner ? GRANT1 : GRANT0;
                end
            end
            GRANT0, GRANT1: begin
                if (!cur_req) begin
                    if (other_req) begin
                        state_d = cur ? GRANT0 : GRANT1;
                        last_d  = ~cur;
                        hold_d  = 4'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if ((hold_inc == HOLD_MAX) && other_req && !cur_lock) begin
                    // Hold budget spent on this access and the other side waits.
                    state_d = cur ? GRANT0 : GRANT1;
                    last_d  = ~cur;
                    hold_d  = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            hold_q    <= 4'd0;
            rd_pend_q <= 1'b0;
            rd_tag_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            rd_pend_q <= rd_pend_d;
            rd_tag_q  <= rd_tag_d;
        end
    end

    assign r0_gnt    = (state_q == GRANT0);
    assign r1_gnt    = (state_q == GRANT1);
    assign r0_rvalid = rd_pend_q && !rd_tag_q;
    assign r1_rvalid = rd_pend_q && rd_tag_q;
    assign rdata     = mem_in;

endmodule
